mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the pipeline's split I/D memory interfaces.
//  Serves the fetch port (read-only) and the data port (read/write, byte mask)
//  from a single word array with programmable access latency.
//  Sits between datapath and backing store; replaces ideal-memory stubs in benches.
//  One transaction in flight at a time; D port wins ties.
// PARAMETERS
//  ADDR_BITS  10  word-index width; array = 2**ADDR_BITS 16-bit words
//  LATENCY    3   cycles from accept to resp (legal 1..15)
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   asynchronous reset, active-low
//  I_mem_address    in   16  fetch byte address
//  I_mem_read       in   1   fetch request, held until resp
//  I_mem_resp       out  1   fetch completion pulse
//  I_mem_rdata      out  16  fetch data, valid with I_mem_resp
//  D_mem_address    in   16  data byte address
//  D_mem_read       in   1   data read request
//  D_mem_write      in   1   data write request (read & write both high = write)
//  mem_byte_enable  in   2   [0] low byte, [1] high byte; writes only
//  D_mem_wdata      in   16  write data
//  D_mem_resp       out  1   data completion pulse
//  D_mem_rdata      out  16  read data, valid with D_mem_resp
//  perf_rd_count    out  16  completed reads (I+D); 0 unless MEMRESP_PERF_EN
//  perf_wr_count    out  16  completed writes; 0 unless MEMRESP_PERF_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM=IDLE, counter=0, both resp=0,
//    both rdata=16'h0000, perf counts=0. Array contents untouched.
//  - Word index = address[ADDR_BITS:1]; address[0] ignored; upper bits alias.
//  - FSM IDLE: sample requests each cycle; D (read|write) beats I_mem_read.
//    On accept latch port id, op, index, wdata, mask; counter=LATENCY-1;
//    go BUSY (or RESP directly if LATENCY=1).
//  - BUSY: decrement counter; at 0 go RESP. Request lines ignored.
//  - RESP (one cycle): resp of owning port=1; read: rdata <= array[index]
//    registered so it is valid exactly in the resp cycle; write: array bytes
//    updated per latched mask at end of this cycle; next state IDLE.
//  - Accept at cycle t -> resp high in cycle t+LATENCY; next accept t+LATENCY+1.
//  - resp is a single-cycle pulse; never high on both ports together.
//  - rdata holds last read value between reads; write resp leaves rdata.
//  - Accepted transaction always completes even if requester drops read/write
//    before resp; requester must ignore stray resp.
//  - Mask 2'b00 write: resp issued, array unchanged.
//  - Read after write to same word returns post-write data.
//  - Reset mid-transaction: transaction discarded, no resp, no array write.
// CONFIGURATION
//  MEMRESP_PERF_EN defined: perf_rd_count/perf_wr_count increment by 1 in each
//   read/write RESP cycle, wrap 16'hFFFF->0, cleared by reset.
//  Not defined: counters not built, both outputs tied to 16'h0000.
// TESTING
//  1 reset low mid-run -> both resp=0, both rdata=0, FSM idle, perf=0.
//  2 preload word 0x0020=16'hBEEF, LATENCY=3, D read 16'h0040 at t=0 ->
//    D_mem_resp=1 only at t=3, D_mem_rdata=16'hBEEF.
//  3 word 0x0020=16'h1234, D write 16'h0041 wdata 16'hAB00 mask 2'b10 ->
//    readback 16'hAB34; mask 2'b00 write -> readback unchanged.
//  4 I read and D read both high at t=0, LATENCY=3 -> D resp t=3,
//    I accepted t=4, I resp t=7, never simultaneous.
//  5 D write accepted, reset low at t=1 -> no resp; later read returns old data.
//  6 MEMRESP_PERF_EN: 3 reads + 2 writes -> perf_rd_count=3, perf_wr_count=2;
//    without macro both stay 0.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory serving a fetch port and a data port, one transaction
// at a time with fixed access latency. Optional perf counters: MEMRESP_PERF_EN.
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] I_mem_address,
  input  logic        I_mem_read,
  output logic        I_mem_resp,
  output logic [15:0] I_mem_rdata,
  input  logic [15:0] D_mem_address,
  input  logic        D_mem_read,
  input  logic        D_mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] D_mem_wdata,
  output logic        D_mem_resp,
  output logic [15:0] D_mem_rdata,
  output logic [15:0] perf_rd_count,
  output logic [15:0] perf_wr_count
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic                 own_d, op_wr;
  logic [ADDR_BITS-1:0] idx;
  logic [15:0]          wdata;
  logic [1:0]           mask;
  logic [15:0]          mem [2**ADDR_BITS];

  logic                 d_req, accept, in_idle;
  logic [ADDR_BITS-1:0] req_idx, cur_idx;
  logic                 cur_d, cur_wr;
  logic                 unused_addr;

  assign d_req   = D_mem_read | D_mem_write;
  assign in_idle = (state == IDLE);
  assign accept  = in_idle & (d_req | I_mem_read);
  assign req_idx = d_req ? D_mem_address[ADDR_BITS:1] : I_mem_address[ADDR_BITS:1];
  assign unused_addr = ^{I_mem_address[15:ADDR_BITS+1], I_mem_address[0],
                         D_mem_address[15:ADDR_BITS+1], D_mem_address[0]};

  // With LATENCY=1 the read is launched straight from IDLE, so use live request fields.
  assign cur_d   = in_idle ? d_req : own_d;
  assign cur_wr  = in_idle ? (d_req & D_mem_write) : op_wr;
  assign cur_idx = in_idle ? req_idx : idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    D_mem_resp = (state == RESP) &  own_d;
    I_mem_resp = (state == RESP) & ~own_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      own_d <= 1'b0;
      op_wr <= 1'b0;
      idx   <= '0;
      wdata <= '0;
      mask  <= '0;
    end else if (accept) begin
      cnt   <= 4'(LATENCY - 1);
      own_d <= d_req;
      op_wr <= d_req & D_mem_write;
      idx   <= req_idx;
      wdata <= D_mem_wdata;
      mask  <= mem_byte_enable;
    end else if (state == BUSY) begin
      cnt   <= cnt - 4'd1;
    end
  end

  // Read data is captured on the edge entering RESP so it is valid only from the resp cycle on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      I_mem_rdata <= '0;
      D_mem_rdata <= '0;
    end else if (state_nxt == RESP && !cur_wr) begin
      if (cur_d) D_mem_rdata <= mem[cur_idx];
      else       I_mem_rdata <= mem[cur_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (state == RESP && op_wr) begin
      if (mask[0]) mem[idx][7:0]  <= wdata[7:0];
      if (mask[1]) mem[idx][15:8] <= wdata[15:8];
    end
  end

`ifdef MEMRESP_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_rd_count <= '0;
      perf_wr_count <= '0;
    end else if (state == RESP) begin
      if (op_wr) perf_wr_count <= perf_wr_count + 16'd1;
      else       perf_rd_count <= perf_rd_count + 16'd1;
    end
  end
`else
  assign perf_rd_count = 16'h0000;
  assign perf_wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=3): latency, byte masks, arbitration,
// aliasing, reset abort and perf counters.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] I_mem_address, D_mem_address, D_mem_wdata;
  logic        I_mem_read, D_mem_read, D_mem_write;
  logic [1:0]  mem_byte_enable;
  logic        I_mem_resp, D_mem_resp;
  logic [15:0] I_mem_rdata, D_mem_rdata, perf_rd_count, perf_wr_count;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] rd;

  mem_responder #(.ADDR_BITS(10), .LATENCY(3)) dut (
    .clk(clk), .reset(reset),
    .I_mem_address(I_mem_address), .I_mem_read(I_mem_read),
    .I_mem_resp(I_mem_resp), .I_mem_rdata(I_mem_rdata),
    .D_mem_address(D_mem_address), .D_mem_read(D_mem_read), .D_mem_write(D_mem_write),
    .mem_byte_enable(mem_byte_enable), .D_mem_wdata(D_mem_wdata),
    .D_mem_resp(D_mem_resp), .D_mem_rdata(D_mem_rdata),
    .perf_rd_count(perf_rd_count), .perf_wr_count(perf_wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a D request, drop it after accept, wait for resp; latency reported in negedges.
  task automatic dop(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                     input logic [1:0] m, input string tag, output logic [15:0] d);
    int k;
    @(negedge clk);
    D_mem_address = a; D_mem_wdata = wd; mem_byte_enable = m;
    D_mem_write = wr; D_mem_read = ~wr;
    @(posedge clk); @(negedge clk);
    D_mem_read = 1'b0; D_mem_write = 1'b0;
    k = 1;
    while (!D_mem_resp && k < 20) begin
      @(negedge clk); k++;
    end
    check({tag, "_lat"}, 16'(k), 16'd3);
    d = D_mem_rdata;
  endtask

  initial begin
    reset = 1'b0;
    I_mem_address = '0; I_mem_read = 1'b0;
    D_mem_address = '0; D_mem_read = 1'b0; D_mem_write = 1'b0;
    D_mem_wdata = '0; mem_byte_enable = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_d_resp", 16'(D_mem_resp), 16'd0);
    check("rst_i_resp", 16'(I_mem_resp), 16'd0);
    check("rst_d_rdata", D_mem_rdata, 16'h0000);
    check("rst_i_rdata", I_mem_rdata, 16'h0000);
    check("rst_perf_rd", perf_rd_count, 16'h0000);
    check("rst_perf_wr", perf_wr_count, 16'h0000);
    reset = 1'b1;

    // Preload word 0x20 then read it with per-cycle resp check; request dropped after accept.
    dop(1'b1, 16'h0040, 16'hBEEF, 2'b11, "pre", rd);
    @(negedge clk);
    D_mem_address = 16'h0040; D_mem_read = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) D_mem_read = 1'b0;
      check($sformatf("rd_d_resp_k%0d", k), 16'(D_mem_resp), 16'(k == 3));
      check($sformatf("rd_i_resp_k%0d", k), 16'(I_mem_resp), 16'd0);
      if (k == 3) check("rd_beef", D_mem_rdata, 16'hBEEF);
    end

    // Byte masks, rdata hold across writes, address aliasing.
    dop(1'b1, 16'h0040, 16'h1234, 2'b11, "w1234", rd);
    dop(1'b1, 16'h0041, 16'hAB00, 2'b10, "whi", rd);
    dop(1'b0, 16'h0040, 16'h0000, 2'b00, "rhi", rd);
    check("mask_hi", rd, 16'hAB34);
    dop(1'b1, 16'h0040, 16'hFFFF, 2'b00, "wnone", rd);
    check("wr_keeps_rdata", rd, 16'hAB34);
    dop(1'b0, 16'h0040, 16'h0000, 2'b00, "rnone", rd);
    check("mask_none", rd, 16'hAB34);
    dop(1'b0, 16'h0841, 16'h0000, 2'b00, "ralias", rd);
    check("alias", rd, 16'hAB34);
    dop(1'b1, 16'h0082, 16'h5A5A, 2'b11, "w41", rd);
    dop(1'b1, 16'h0082, 16'h00C3, 2'b01, "w41lo", rd);

    // Simultaneous requests: D first, I accepted one cycle after D resp.
    @(negedge clk);
    I_mem_address = 16'h0040; I_mem_read = 1'b1;
    D_mem_address = 16'h0082; D_mem_read = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("arb_d_k%0d", k), 16'(D_mem_resp), 16'(k == 3));
      check($sformatf("arb_i_k%0d", k), 16'(I_mem_resp), 16'(k == 7));
      if (k == 3) begin
        check("arb_d_data", D_mem_rdata, 16'h5AC3);
        D_mem_read = 1'b0;
      end
      if (k == 7) begin
        check("arb_i_data", I_mem_rdata, 16'hAB34);
        I_mem_read = 1'b0;
      end
    end

    // Reset while a write is in flight: no resp, no array update.
    @(negedge clk);
    D_mem_address = 16'h0040; D_mem_wdata = 16'h0000; mem_byte_enable = 2'b11; D_mem_write = 1'b1;
    @(posedge clk); @(negedge clk);
    D_mem_write = 1'b0; reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("abort_resp_k%0d", k), 16'({D_mem_resp, I_mem_resp}), 16'd0);
    end
    check("abort_d_rdata", D_mem_rdata, 16'h0000);
    check("abort_i_rdata", I_mem_rdata, 16'h0000);
    reset = 1'b1;
    dop(1'b0, 16'h0040, 16'h0000, 2'b00, "rabort", rd);
    check("abort_old_data", rd, 16'hAB34);

    // Perf counters: 3 reads and 2 writes since the reset above.
    dop(1'b0, 16'h0082, 16'h0000, 2'b00, "p_r2", rd);
    check("p_r2_data", rd, 16'h5AC3);
    dop(1'b1, 16'h0100, 16'hC0DE, 2'b11, "p_w1", rd);
    dop(1'b1, 16'h0101, 16'h1100, 2'b10, "p_w2", rd);
    dop(1'b0, 16'h0100, 16'h0000, 2'b00, "p_r3", rd);
    check("p_r3_data", rd, 16'h11DE);
    @(negedge clk);
`ifdef MEMRESP_PERF_EN
    check("perf_rd", perf_rd_count, 16'd3);
    check("perf_wr", perf_wr_count, 16'd2);
`else
    check("perf_rd_off", perf_rd_count, 16'd0);
    check("perf_wr_off", perf_wr_count, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
